// File: rtl/avalon_mem_pkg.sv
// avalon_mem_pkg
// Shared definitions for the wait-state Avalon-MM memory model: the
// transfer-sequencing states, the wait-count type, the random wait
// generator's feedback taps, and helpers for region decode and the LFSR step.
package avalon_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [3:0] wait_t;

  // Right-shifting Galois mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // The limit is computed in 34 bits so a region ending at the top of the
  // 4 GiB space does not wrap.
  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned words);
    logic [33:0] lo;
    logic [33:0] hi;
    logic [33:0] a;
    lo = {2'b00, base};
    hi = lo + ({2'b00, words} << 2);
    a  = {2'b00, addr};
    return (a >= lo) && (a < hi);
  endfunction

  function automatic logic [29:0] region_index(input logic [31:0] addr,
                                               input logic [31:0] base);
    return 30'((addr - base) >> 2);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/avalon_wait_gen.sv
// avalon_wait_gen
// Sequences one Avalon transfer through IDLE/WAIT/DONE. It chooses the
// wait count for the transfer (fixed or LFSR-driven), counts it down, and
// reports when the transfer completes and when the master dropped its
// request part-way through.
//
// Ports
//   clk_i       clock
//   reset_i     synchronous active-high reset
//   req_i       read or write request present
//   complete_o  transfer completes in this cycle
//   abort_o     request withdrawn while a transfer was in progress
module avalon_wait_gen
  import avalon_mem_pkg::*;
#(
  parameter int          WAIT_MODE   = 0,
  parameter int          WAIT_CYCLES = 0,
  parameter int          MAX_WAIT    = 7,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_i,
  output logic complete_o,
  output logic abort_o
);

  state_e      state_q, state_d;
  wait_t       count_q, count_d;
  logic [15:0] lfsr_q, lfsr_d;
  wait_t       waitSel;

  // Wait count for a transfer that starts in this cycle
  assign waitSel = (WAIT_MODE == 1)
                   ? wait_t'({1'b0, lfsr_q[3:0]} % 5'(MAX_WAIT + 1))
                   : wait_t'(WAIT_CYCLES);

  // Next-state logic. DONE is the completion cycle, so a transfer with W
  // waits spends W-1 cycles in WAIT; count_q holds the WAIT cycles left.
  // While reset is high nothing completes, so waitrequest stays up and
  // the memory is untouched.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lfsr_d     = lfsr_q;
    complete_o = 1'b0;
    abort_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          lfsr_d = lfsr_next(lfsr_q);
          if (waitSel == 4'd0) begin
            complete_o = 1'b1;
          end else if (waitSel == 4'd1) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            count_d = waitSel - 4'd1;
          end
        end
      end
      WAIT: begin
        if (!req_i) begin
          abort_o = 1'b1;
          state_d = IDLE;
          count_d = 4'd0;
        end else begin
          count_d = count_q - 4'd1;
          if (count_q == 4'd1) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = 4'd0;
        if (req_i) complete_o = 1'b1;
        else abort_o = 1'b1;
      end
      default: begin
        state_d = IDLE;
        count_d = 4'd0;
      end
    endcase
    if (reset_i) begin
      complete_o = 1'b0;
      abort_o    = 1'b0;
    end
  end

  // State, counter and LFSR registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lfsr_q  <= lfsr_d;
    end
  end

endmodule

// File: rtl/avalon_mem_ws.sv
// avalon_mem_ws
// Avalon-MM slave memory model with two address regions (low data region,
// high region at the reset vector), byteenable on reads and writes, and a
// programmable or pseudo-random number of wait states per transfer.
// Out-of-region, read+write and abandoned transfers raise a sticky error.
//
// Ports
//   clk           clock
//   reset         synchronous active-high reset (memory contents kept)
//   address       byte address, bits [1:0] ignored
//   read, write   transfer requests
//   writedata     write data
//   byteenable    lane enables, bit n covers bits [8n+7:8n]
//   waitrequest   high while the transfer has not been accepted
//   readdata      read data in the completing cycle, otherwise zero
//   access_error  sticky error flag, cleared only by reset
module avalon_mem_ws
  import avalon_mem_pkg::*;
#(
  parameter logic [31:0] LOW_BASE       = 32'h00000000,
  parameter int unsigned LOW_WORDS      = 1024,
  parameter logic [31:0] HIGH_BASE      = 32'hBFC00000,
  parameter int unsigned HIGH_WORDS     = 4096,
  parameter              LOW_INIT_FILE  = "",
  parameter              HIGH_INIT_FILE = "",
  parameter int          WAIT_MODE      = 0,
  parameter int          WAIT_CYCLES    = 0,
  parameter int          MAX_WAIT       = 7,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        access_error
);

  localparam int LOW_AW  = (LOW_WORDS  > 1) ? $clog2(LOW_WORDS)  : 1;
  localparam int HIGH_AW = (HIGH_WORDS > 1) ? $clog2(HIGH_WORDS) : 1;

  logic [31:0] lowMem  [LOW_WORDS];
  logic [31:0] highMem [HIGH_WORDS];

  logic               lowHit, highHit, anyHit, bothReq;
  logic [LOW_AW-1:0]  lowIdx;
  logic [HIGH_AW-1:0] highIdx;
  logic               complete, abort;
  logic               readOk, wrLow, wrHigh;
  logic [31:0]        rdWord;
  logic               accessErr_q, accessErr_d;

  // Both regions start zero-filled
  initial begin
    for (int i = 0; i < LOW_WORDS; i++) lowMem[LOW_AW'(i)] = 32'h0;
    for (int i = 0; i < HIGH_WORDS; i++) highMem[HIGH_AW'(i)] = 32'h0;
  end

  // The low region takes priority if the two windows were set to overlap
  assign lowHit  = region_hit(address, LOW_BASE, LOW_WORDS);
  assign highHit = !lowHit && region_hit(address, HIGH_BASE, HIGH_WORDS);
  assign anyHit  = lowHit || highHit;
  assign lowIdx  = LOW_AW'(region_index(address, LOW_BASE));
  assign highIdx = HIGH_AW'(region_index(address, HIGH_BASE));
  assign bothReq = read && write;

  avalon_wait_gen #(
    .WAIT_MODE  (WAIT_MODE),
    .WAIT_CYCLES(WAIT_CYCLES),
    .MAX_WAIT   (MAX_WAIT),
    .LFSR_SEED  (LFSR_SEED)
  ) u_wait_gen (
    .clk_i     (clk),
    .reset_i   (reset),
    .req_i     (read || write),
    .complete_o(complete),
    .abort_o   (abort)
  );

  assign waitrequest = (read || write) && !complete;

  // Only a clean single-direction transfer that hits a region touches memory
  assign readOk = complete && read  && !write && anyHit;
  assign wrLow  = complete && write && !read  && lowHit;
  assign wrHigh = complete && write && !read  && highHit;

  // Word selected by the current address
  always_comb begin
    rdWord = 32'h0;
    if (lowHit) rdWord = lowMem[lowIdx];
    else if (highHit) rdWord = highMem[highIdx];
  end

  // Disabled lanes read back as zero
  always_comb begin
    readdata = 32'h0;
    if (readOk) begin
      for (int n = 0; n < 4; n++) begin
        if (byteenable[n]) readdata[8*n +: 8] = rdWord[8*n +: 8];
      end
    end
  end

  // Lane-masked writes; no reset branch since the memory survives reset
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (wrLow && byteenable[n])  lowMem[lowIdx][8*n +: 8]   <= writedata[8*n +: 8];
      if (wrHigh && byteenable[n]) highMem[highIdx][8*n +: 8] <= writedata[8*n +: 8];
    end
  end

  // Misses, read+write collisions and abandoned transfers latch the error
  assign accessErr_d = accessErr_q || abort || (complete && (bothReq || !anyHit));

  always_ff @(posedge clk) begin
    if (reset) accessErr_q <= 1'b0;
    else accessErr_q <= accessErr_d;
  end

  assign access_error = accessErr_q;

endmodule

// File: tb/tb_avalon_mem_ws.sv
// tb_avalon_mem_ws
// Drives two instances of the memory model: one with pseudo-random wait
// states and one with three fixed wait states. Every transfer pushes its
// expected wait count and read data into a queue; a monitor pops and
// compares whenever the selected instance drops waitrequest.
module tb_avalon_mem_ws;

  localparam logic [31:0] HB       = 32'hBFC00000;
  localparam int          WORDS    = 64;
  localparam int          FIX_WAIT = 3;
  localparam int          MAXW     = 7;
  localparam logic [15:0] SEED     = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic [3:0]  byteenable = 4'h0;
  logic        readR = 1'b0, writeR = 1'b0, readF = 1'b0, writeF = 1'b0;
  logic        waitR, waitF, errR, errF;
  logic [31:0] rdataR, rdataF;

  always #5 clk = ~clk;

  avalon_mem_ws #(
    .LOW_WORDS(WORDS), .HIGH_WORDS(WORDS), .WAIT_MODE(1),
    .MAX_WAIT(MAXW), .LFSR_SEED(SEED)
  ) dutRnd (
    .clk(clk), .reset(reset), .address(address), .read(readR), .write(writeR),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitR),
    .readdata(rdataR), .access_error(errR)
  );

  avalon_mem_ws #(
    .LOW_WORDS(WORDS), .HIGH_WORDS(WORDS), .WAIT_MODE(0),
    .WAIT_CYCLES(FIX_WAIT), .LFSR_SEED(SEED)
  ) dutFix (
    .clk(clk), .reset(reset), .address(address), .read(readF), .write(writeF),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitF),
    .readdata(rdataF), .access_error(errF)
  );

  typedef struct {
    logic [31:0] data;
    int          waits;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          curDut = 0;
  int          obsW[$];
  int          firstW[$];
  logic [31:0] modelMem [longint];
  bit          errM [2];
  logic [15:0] lfsrM = SEED;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Region of an address: 0 low, 1 high, -1 unmapped
  function automatic int regionOf(input logic [31:0] a);
    longint x;
    x = longint'(a);
    if (x < 4 * WORDS) return 0;
    if (x >= longint'(HB) && x < longint'(HB) + 4 * WORDS) return 1;
    return -1;
  endfunction

  function automatic longint keyOf(input int dut, input logic [31:0] a);
    return (longint'(dut) << 33) + longint'(a & 32'hFFFFFFFC);
  endfunction

  function automatic logic [31:0] memRead(input int dut, input logic [31:0] a);
    if (modelMem.exists(keyOf(dut, a))) return modelMem[keyOf(dut, a)];
    return 32'h0;
  endfunction

  // Wait count of the next transfer: random instance follows the seeded LFSR
  function automatic int nextWait(input int dut);
    int w;
    if (dut == 1) return FIX_WAIT;
    w = int'(lfsrM & 16'h000F) % (MAXW + 1);
    lfsrM = (lfsrM >> 1) ^ ((lfsrM & 16'h0001) != 0 ? 16'hB400 : 16'h0000);
    return w;
  endfunction

  // Issue one transfer and hold it until accepted; leaves the bus driven so
  // the next call starts back-to-back.
  task automatic applyStimulus(input int dut, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] be);
    int          rg;
    logic [31:0] old, expd, nw;
    exp_t        e;
    bit          done;
    bit          errBefore;
    rg   = regionOf(addr);
    old  = memRead(dut, addr);
    expd = 32'h0;
    if (rd && !wr && rg >= 0)
      for (int n = 0; n < 4; n++) if (be[n]) expd[8*n +: 8] = old[8*n +: 8];
    e.data  = expd;
    e.waits = nextWait(dut);
    expQ.push_back(e);
    errBefore  = errM[dut];
    curDut     = dut;
    address    = addr;
    writedata  = wd;
    byteenable = be;
    readR  = (dut == 0) && rd;
    writeR = (dut == 0) && wr;
    readF  = (dut == 1) && rd;
    writeF = (dut == 1) && wr;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!((dut == 0) ? waitR : waitF)) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: waitrequest still high after 40 cycles, addr %h", addr);
      if (expQ.size() > 0) void'(expQ.pop_back());
    end else begin
      checkOutput("err_before_event", (dut == 0) ? errR : errF, errBefore);
      if (wr && !rd && rg >= 0) begin
        nw = old;
        for (int n = 0; n < 4; n++) if (be[n]) nw[8*n +: 8] = wd[8*n +: 8];
        modelMem[keyOf(dut, addr)] = nw;
      end
      if ((rd && wr) || rg < 0) errM[dut] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus();
    readR = 1'b0; writeR = 1'b0; readF = 1'b0; writeF = 1'b0;
    @(negedge clk);
    checkOutput("err_rnd", errR, errM[0]);
    checkOutput("err_fix", errF, errM[1]);
    checkOutput("wait_idle_rnd", waitR, 1'b0);
    checkOutput("wait_idle_fix", waitF, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    errM[0] = 1'b0;
    errM[1] = 1'b0;
    lfsrM = SEED;
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] base;
    base = ($urandom_range(1, 0) == 1) ? HB : 32'h0;
    return base + 32'($urandom_range(WORDS - 1, 0) * 4) + 32'($urandom_range(3, 0));
  endfunction

  // Monitor: counts waitrequest-high cycles of the selected instance and
  // checks each completion against the head of the expectation queue
  initial begin : monitor
    int          hi;
    exp_t        e;
    logic        cr, cw, cwait;
    logic [31:0] crd;
    hi = 0;
    forever begin
      @(negedge clk);
      cr    = (curDut == 0) ? readR  : readF;
      cw    = (curDut == 0) ? writeR : writeF;
      cwait = (curDut == 0) ? waitR  : waitF;
      crd   = (curDut == 0) ? rdataR : rdataF;
      if (reset) begin
        hi = 0;
      end else if (cr || cw) begin
        if (cwait) begin
          hi++;
          checkOutput("rdata_while_waiting", crd, 32'h0);
        end else begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_completion: got completion expected none");
          end else begin
            e = expQ.pop_front();
            checkOutput("wait_count", 64'(hi), 64'(e.waits));
            checkOutput("readdata", crd, e.data);
            if (curDut == 0) obsW.push_back(hi);
          end
          hi = 0;
        end
      end else begin
        hi = 0;
        checkOutput("rdata_idle", crd, 32'h0);
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bit seen [8];
    doReset();
    idleBus();

    // Random-wait instance: full-word write/readback, then a random mix
    applyStimulus(0, 1, 0, 32'h10, 32'h0, 4'hF);
    applyStimulus(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    applyStimulus(0, 1, 0, 32'h10, 32'h0, 4'hF);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(3, 0) == 0)
        applyStimulus(0, 0, 1, randAddr(), $urandom, 4'($urandom_range(15, 0)));
      else
        applyStimulus(0, 1, 0, randAddr(), 32'h0, 4'($urandom_range(15, 0)));
    end
    idleBus();
    foreach (obsW[i]) if (obsW[i] >= 0 && obsW[i] <= MAXW) seen[obsW[i]] = 1'b1;
    for (int v = 0; v <= MAXW; v++) checkOutput("wait_value_seen", seen[v], 1'b1);
    for (int i = 0; i < 20; i++) firstW.push_back(obsW[i]);

    // Same seed after reset must replay the same wait sequence
    obsW.delete();
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, randAddr(), 32'h0, 4'hF);
    idleBus();
    for (int i = 0; i < 20; i++) checkOutput("wait_replay", 64'(obsW[i]), 64'(firstW[i]));

    // Fixed three-wait instance: lane merges on write and read
    applyStimulus(1, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    applyStimulus(1, 1, 0, 32'h10, 32'h0, 4'hF);
    applyStimulus(1, 0, 1, 32'h10, 32'h000000AB, 4'b0001);
    applyStimulus(1, 1, 0, 32'h10, 32'h0, 4'hF);
    applyStimulus(1, 1, 0, 32'h10, 32'h0, 4'b1100);
    applyStimulus(1, 0, 1, 32'h10, 32'h12345678, 4'h0);
    applyStimulus(1, 1, 0, 32'h13, 32'h0, 4'hF);
    applyStimulus(1, 0, 1, HB, 32'h24020005, 4'hF);
    applyStimulus(1, 1, 0, HB, 32'h0, 4'hF);
    applyStimulus(1, 0, 1, 32'h20, 32'h11111111, 4'hF);
    idleBus();
    checkOutput("model_byte_merge", memRead(1, 32'h10), 32'hDEADBEAB);

    // Unmapped read on the random instance: zero data, sticky error
    applyStimulus(0, 1, 0, 32'h80000000, 32'h0, 4'hF);
    idleBus();
    applyStimulus(0, 1, 0, 32'h10, 32'h0, 4'hF);
    applyStimulus(0, 0, 1, 32'h14, 32'hCAFEF00D, 4'hF);
    idleBus();

    // Read and write together on the fixed instance
    applyStimulus(1, 1, 1, 32'h10, 32'hFFFFFFFF, 4'hF);
    idleBus();
    applyStimulus(1, 1, 0, 32'h10, 32'h0, 4'hF);
    idleBus();

    // Master withdraws a read after one wait cycle
    void'(nextWait(1));
    curDut = 1; address = 32'h10; byteenable = 4'hF; readF = 1'b1;
    @(negedge clk);
    checkOutput("wait_before_drop", waitF, 1'b1);
    @(posedge clk); #1;
    readF = 1'b0;
    errM[1] = 1'b1;
    idleBus();

    // Reset in the middle of a write's wait phase: no memory effect
    curDut = 1; address = 32'h20; writedata = 32'hFFFFFFFF; byteenable = 4'hF;
    writeF = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("wait_in_reset", waitF, 1'b1);
    @(posedge clk); #1;
    writeF = 1'b0;
    reset = 1'b0;
    errM[0] = 1'b0;
    errM[1] = 1'b0;
    lfsrM = SEED;
    idleBus();
    applyStimulus(1, 1, 0, 32'h20, 32'h0, 4'hF);
    idleBus();
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
